// File: rtl/times3_code_decoder.sv
// ============================================================================
// Module   : times3_code_decoder
// Brief    : Decodes x3 codewords (0x0/0x3/0x6/0x9) back to {a,b}, flags other
//            values as errors, and queues results in a small output FIFO.
//            Optional macro TIMES3_ERR_CNT_EN builds the saturating err_cnt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module times3_code_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int             PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

  logic [2:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic       w_dec_err;
  logic [1:0] w_dec_ab;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_head;

  always_comb begin
    w_dec_err = 1'b0;
    w_dec_ab  = 2'b00;
    unique case (y)
      4'h0:    w_dec_ab  = 2'b00;
      4'h3:    w_dec_ab  = 2'b01;
      4'h6:    w_dec_ab  = 2'b10;
      4'h9:    w_dec_ab  = 2'b11;
      default: w_dec_err = 1'b1;
    endcase
  end

  // in_ready is a pure function of occupancy: a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {w_dec_err, w_dec_ab};
  end

  assign w_head              = mem_q[rd_ptr_q];
  assign {out_err, a, b}     = out_valid ? w_head : 3'b000;

`ifdef TIMES3_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_cnt_q <= '0;
    end else if (w_push && w_dec_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

`default_nettype wire
